stream_arb_mux: RTL and testbench
=================================

STREAM_ARB_MUX -- requirements
Module: stream_arb_mux

Interface
REQ-001 SHALL have parameter DataWidth, default 32, payload width in bits.
REQ-002 SHALL have parameter NumInputs, default 8, number of requesting input streams (>=1).
REQ-003 SHALL derive localparam SelWidth = $clog2(NumInputs), forced to 1 when that is 0.
REQ-004 SHALL have one clock and a synchronous, active-low reset: clk_i input 1 rising-edge clock; rst_ni input 1 synchronous active-low reset.
REQ-005 valid_i  input  [NumInputs]  per-input payload valid.
REQ-006 ready_o  output  [NumInputs]  per-input accept; handshake on input k when valid_i[k] & ready_o[k].
REQ-007 data_i  input  [DataWidth-1:0] x [NumInputs] (unpacked)  per-input payload.
REQ-008 valid_o  output  1  output register holds a payload.
REQ-009 ready_i  input  1  downstream accept; output handshake when valid_o & ready_i.
REQ-010 data_o  output  DataWidth  registered payload.
REQ-011 sel_o  output  SelWidth  index of the input that supplied data_o.

Function
REQ-012 SHALL hold a single-entry output register (data_o, sel_o, valid_o).
REQ-013 Register SHALL load when (!valid_o | ready_i) and at least one valid_i is set.
REQ-014 At most one ready_o bit SHALL be high per cycle: the granted index, only when the load condition holds; all others low.
REQ-015 ready_o SHALL NOT depend on ready_i except through the load condition; no ready_o when no valid_i is set.
REQ-016 Latency: input handshake in cycle t -> valid_o=1 with that payload in cycle t+1.
REQ-017 Throughput: one payload per cycle when ready_i is held high (simultaneous drain and load in the same cycle).
REQ-018 While valid_o & !ready_i, data_o and sel_o SHALL stay stable and all ready_o SHALL be 0.
REQ-019 Drain without a new load SHALL clear valid_o next cycle; data_o/sel_o keep their last values.
REQ-020 Round-robin: priority pointer p; grant = first set valid_i at index p, p+1, ... NumInputs-1, 0, ... p-1 (wrap-around).
REQ-021 On an input handshake at index g, p SHALL become (g+1) mod NumInputs; p SHALL be unchanged otherwise.
REQ-022 valid_i deasserted before its handshake SHALL carry no penalty: no grant is held or locked across cycles.
REQ-023 NumInputs=1: grant is always 0; sel_o is constant 0; behaves as a one-entry pipeline register.

Reset
REQ-024 When rst_ni=0 at a clock edge: valid_o=0, data_o='0, sel_o='0, p=0; all ready_o=0 while rst_ni=0.
REQ-025 Reset mid-transfer SHALL discard the held entry; no payload is emitted after release until a new input handshake.

Configuration
REQ-026 Macro STREAM_ARB_MUX_RR_EN defined: round-robin per REQ-020/021.
REQ-027 Macro undefined: fixed priority, lowest set valid_i index wins; pointer logic is not built; all other behaviour unchanged.

Structure
REQ-028 Package stream_arb_mux_pkg SHALL hold default-width constants (DEF_DATA_WIDTH=32, DEF_NUM_INPUTS=8) and the sel index typedef helper.
REQ-029 Grant computation and pointer SHALL live in sub-module rr_arbiter (inputs: clk_i, rst_ni, req, advance; output: one-hot grant and index).
REQ-030 Top level SHALL contain only the output register, load/ready logic and the data-select mux.

Verification
REQ-031 Reset, NumInputs=8: valid_i=8'hFF during rst_ni=0 -> ready_o=0, valid_o=0; after release, first grant is index 0.
REQ-032 RR_EN, valid_i=8'hFF held, ready_i=1 -> sel_o sequence 0,1,2,...,7,0 on consecutive cycles; one output per cycle.
REQ-033 RR_EN, p=6, valid_i=8'b0000_0101 -> grant 0 (wrap), then p=1, next grant 2.
REQ-034 Backpressure: load data_i[3]=32'hDEAD_BEEF, ready_i=0 for 5 cycles -> data_o/sel_o=3 stable, ready_o=0; ready_i=1 -> drained next edge.
REQ-035 Macro undefined, valid_i=8'b1010_0000 for 3 handshakes -> sel_o=5 each time.
REQ-036 Reset asserted with valid_o=1 -> valid_o=0 next cycle; no stale payload appears after release.

Source files
------------

// File: rtl/stream_arb_mux_pkg.sv
// stream_arb_mux_pkg
//   Shared constants and helpers for the stream_arb_mux slice.
//   DEF_DATA_WIDTH / DEF_NUM_INPUTS : default parameter values.
//   sel_width()                     : index width for a given input count (min 1).
//   def_sel_t                       : index type at the default input count.
package stream_arb_mux_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_INPUTS = 8;

    function automatic int sel_width(input int num_inputs);
        return (num_inputs > 1) ? $clog2(num_inputs) : 1;
    endfunction

    typedef logic [sel_width(DEF_NUM_INPUTS)-1:0] def_sel_t;

endpackage

// File: rtl/stream_arb_mux_rr_arbiter.sv
// rr_arbiter
//   Grant selection for stream_arb_mux.
//   Macro STREAM_ARB_MUX_RR_EN defined   : round-robin from a priority pointer
//                                          that moves past each granted index.
//   Macro STREAM_ARB_MUX_RR_EN undefined : fixed priority, lowest index wins;
//                                          no pointer is built.
//   Ports:
//     clk_i, rst_ni : clock, synchronous active-low reset (pointer only)
//     req           : per-input request
//     advance       : a handshake happens this cycle on the granted index
//     grant         : one-hot grant (all zero when no request)
//     grant_idx     : index of the granted input
module rr_arbiter
    import stream_arb_mux_pkg::*;
#(
    parameter int NumInputs = DEF_NUM_INPUTS,
    localparam int SelWidth = sel_width(NumInputs)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NumInputs-1:0] req,
    input  logic                 advance,
    output logic [NumInputs-1:0] grant,
    output logic [SelWidth-1:0]  grant_idx
);

`ifdef STREAM_ARB_MUX_RR_EN
    logic [SelWidth-1:0] ptr;
    int unsigned         k;
    logic                found;

    // Scan starting at the pointer, wrapping at NumInputs (not a power of two
    // in general, so the wrap is an explicit subtract rather than a mask).
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        k         = 0;
        for (int unsigned i = 0; i < NumInputs; i++) begin
            k = int'(ptr) + i;
            if (k >= NumInputs) begin
                k = k - NumInputs;
            end
            if (!found && req[k]) begin
                found     = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = SelWidth'(k);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr <= '0;
        end else if (advance) begin
            if (int'(grant_idx) == NumInputs - 1) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + SelWidth'(1);
            end
        end
    end
`else
    logic found;
    logic unused_fixed;

    assign unused_fixed = ^{clk_i, rst_ni, advance};

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < NumInputs; i++) begin
            if (!found && req[i]) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = SelWidth'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/stream_arb_mux.sv
// stream_arb_mux
//   N-input stream arbiter feeding a single-entry output register.
//   Arbitration policy chosen by macro STREAM_ARB_MUX_RR_EN (round-robin when
//   defined, fixed lowest-index priority otherwise).
//   Ports:
//     clk_i, rst_ni      : clock, synchronous active-low reset
//     valid_i / ready_o  : per-input handshake (at most one ready_o high)
//     data_i             : per-input payload (unpacked array)
//     valid_o / ready_i  : output handshake
//     data_o, sel_o      : registered payload and index of its source input
module stream_arb_mux
    import stream_arb_mux_pkg::*;
#(
    parameter int DataWidth = DEF_DATA_WIDTH,
    parameter int NumInputs = DEF_NUM_INPUTS,
    localparam int SelWidth = sel_width(NumInputs)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NumInputs-1:0] valid_i,
    output logic [NumInputs-1:0] ready_o,
    input  logic [DataWidth-1:0] data_i [NumInputs],
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [DataWidth-1:0] data_o,
    output logic [SelWidth-1:0]  sel_o
);

    logic [NumInputs-1:0] grant;
    logic [SelWidth-1:0]  grant_idx;
    logic                 load;
    logic [DataWidth-1:0] sel_data;

    // Register takes a new entry when empty or draining this cycle; reset
    // forces no acceptance.
    assign load    = rst_ni & (~valid_o | ready_i) & (|valid_i);
    assign ready_o = grant & {NumInputs{load}};

    rr_arbiter #(
        .NumInputs (NumInputs)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req       (valid_i),
        .advance   (load),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // One-hot AND-OR select keeps the mux free of out-of-range indexing.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NumInputs; i++) begin
            if (grant[i]) begin
                sel_data = data_i[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            sel_o   <= '0;
        end else if (load) begin
            valid_o <= 1'b1;
            data_o  <= sel_data;
            sel_o   <= grant_idx;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_arb_mux.sv
// tb_stream_arb_mux
//   Directed scenarios plus randomized traffic against a behavioural model of
//   the arbiter/register. Follows STREAM_ARB_MUX_RR_EN like the design.
module tb_stream_arb_mux;

    localparam int N  = 8;
    localparam int DW = 32;

    logic          clk_i;
    logic          rst_ni;
    logic [N-1:0]  valid_i;
    logic [N-1:0]  ready_o;
    logic [DW-1:0] data_i [N];
    logic          valid_o;
    logic          ready_i;
    logic [DW-1:0] data_o;
    logic [2:0]    sel_o;

    int n_cmp;
    int n_err;

    stream_arb_mux #(
        .DataWidth (DW),
        .NumInputs (N)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .sel_o   (sel_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Winner = set request with the smallest forward distance from the
    // priority pointer; pointer stays at 0 in fixed-priority builds.
    bit          m_live;
    bit          m_valid;
    logic [31:0] m_data;
    int          m_sel;
    int          m_ptr;

    function automatic int pick(input logic [N-1:0] v, input int p);
        int best;
        int bestd;
        best  = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
            if (v[i] && ((i - p + N) % N) < bestd) begin
                bestd = (i - p + N) % N;
                best  = i;
            end
        end
        return best;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        g = pick(valid_i, m_ptr);
        if (rst_ni && (!m_valid || ready_i) && g >= 0) return N'(1) << g;
        return '0;
    endfunction

    always @(posedge clk_i) begin
        int g;
        if (!rst_ni) begin
            m_live  = 1'b1;
            m_valid = 1'b0;
            m_data  = '0;
            m_sel   = 0;
            m_ptr   = 0;
        end else if (m_live) begin
            g = pick(valid_i, m_ptr);
            if ((!m_valid || ready_i) && g >= 0) begin
                m_valid = 1'b1;
                m_data  = data_i[g];
                m_sel   = g;
`ifdef STREAM_ARB_MUX_RR_EN
                m_ptr   = (g + 1) % N;
`endif
            end else if (ready_i) begin
                m_valid = 1'b0;
            end
        end
    end

    // Compare process: every cycle once the model has seen reset.
    always @(negedge clk_i) begin
        if (m_live) begin
            cmp("valid_o", 64'(valid_o), 64'(m_valid));
            cmp("data_o", 64'(data_o), 64'(m_data));
            cmp("sel_o", 64'(sel_o), 64'(m_sel));
            cmp("ready_o", 64'(ready_o), 64'(exp_ready()));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst_ni  = 1'b0;
        ready_i = 1'b0;
        valid_i = 8'hFF;
        for (int i = 0; i < N; i++) data_i[i] = 32'h1000_0000 + 32'(i);

        // Reset with all inputs requesting.
        tick();
        tick();
        cmp("rst_ready_o", 64'(ready_o), 64'h0);
        cmp("rst_valid_o", 64'(valid_o), 64'h0);
        cmp("rst_data_o", 64'(data_o), 64'h0);

        // First grant after release is index 0 in both builds.
        rst_ni  = 1'b1;
        ready_i = 1'b1;
        settle();
        cmp("first_grant", 64'(ready_o), 64'h01);
        tick();
        cmp("first_sel", 64'(sel_o), 64'h0);
        cmp("first_data", 64'(data_o), 64'h1000_0000);

        // Full request with ready held: one output per cycle.
        for (int k = 1; k <= 8; k++) begin
            tick();
            cmp("stream_valid", 64'(valid_o), 64'h1);
`ifdef STREAM_ARB_MUX_RR_EN
            cmp("rr_seq_sel", 64'(sel_o), 64'(k % 8));
`else
            cmp("fixed_seq_sel", 64'(sel_o), 64'h0);
`endif
        end

        // Grant index 5 (pointer -> 6 in RR), then requests 0 and 2.
        valid_i = 8'h20;
        tick();
        cmp("sel5", 64'(sel_o), 64'h5);
        valid_i = 8'h05;
        settle();
        cmp("wrap_ready", 64'(ready_o), 64'h01);
        tick();
        cmp("wrap_sel", 64'(sel_o), 64'h0);
`ifdef STREAM_ARB_MUX_RR_EN
        cmp("after_wrap_ready", 64'(ready_o), 64'h04);
        tick();
        cmp("after_wrap_sel", 64'(sel_o), 64'h2);
`else
        cmp("after_wrap_ready", 64'(ready_o), 64'h01);
        tick();
        cmp("after_wrap_sel", 64'(sel_o), 64'h0);
        // Fixed priority: 5 beats 7 every time.
        valid_i = 8'hA0;
        for (int k = 0; k < 3; k++) begin
            tick();
            cmp("fixed_sel5", 64'(sel_o), 64'h5);
        end
`endif

        // Backpressure: hold DEADBEEF from input 3 for five stalled cycles.
        valid_i   = 8'h08;
        data_i[3] = 32'hDEAD_BEEF;
        tick();
        ready_i = 1'b0;
        valid_i = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            settle();
            cmp("bp_ready_o", 64'(ready_o), 64'h0);
            tick();
            cmp("bp_data_o", 64'(data_o), 64'hDEAD_BEEF);
            cmp("bp_sel_o", 64'(sel_o), 64'h3);
            cmp("bp_valid_o", 64'(valid_o), 64'h1);
        end
        ready_i = 1'b1;
        valid_i = 8'h00;
        tick();
        cmp("drain_valid_o", 64'(valid_o), 64'h0);
        cmp("drain_keep_data", 64'(data_o), 64'hDEAD_BEEF);
        cmp("drain_keep_sel", 64'(sel_o), 64'h3);

        // Reset while holding an entry.
        valid_i = 8'h01;
        tick();
        cmp("pre_rst_valid", 64'(valid_o), 64'h1);
        ready_i = 1'b0;
        rst_ni  = 1'b0;
        settle();
        cmp("mid_rst_ready", 64'(ready_o), 64'h0);
        tick();
        cmp("mid_rst_valid", 64'(valid_o), 64'h0);
        rst_ni  = 1'b1;
        ready_i = 1'b1;
        valid_i = 8'h00;
        for (int k = 0; k < 3; k++) begin
            tick();
            cmp("no_stale", 64'(valid_o), 64'h0);
        end

        // Randomized traffic; the compare process does the checking.
        for (int c = 0; c < 3000; c++) begin
            rst_ni  = ($urandom_range(0, 199) != 0);
            ready_i = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 3))
                0: valid_i = '0;
                1: valid_i = N'(1) << $urandom_range(0, N - 1);
                default: valid_i = N'($urandom);
            endcase
            for (int i = 0; i < N; i++) data_i[i] = $urandom;
            tick();
        end

        @(posedge clk_i);
        @(negedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
